digit_entry_reg: RTL and testbench

- Parametrised multi-mode digit register for the calculator keypad/operand path.
- Holds COUNT digits of WIDTH bits each.
- Supports directional shift-in, backspace, rotate, parallel load and clear.
- Tracks how many digits have been entered, and flags overflow, rejection and invalid-digit events for the display and control FSM.

---
 rtl/digit_entry_reg_if.sv | 30 +++
 rtl/digit_entry_reg.sv | 111 +++++++++++
 tb/tb_digit_entry_reg.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/digit_entry_reg_if.sv
// Operand-path bus for the keypad digit register: command inputs and
// contents/status outputs. The clock and reset stay outside the bundle.
interface digit_entry_reg_if #(
  parameter int COUNT = 4,
  parameter int WIDTH = 4
);
  localparam int DW = $clog2(COUNT + 1);

  logic                   en;
  logic [2:0]             op;
  logic                   dir;
  logic [WIDTH-1:0]       in;
  logic [COUNT*WIDTH-1:0] load_data;
  logic [COUNT*WIDTH-1:0] out;
  logic [DW-1:0]          depth;
  logic                   full;
  logic                   empty;
  logic                   ovf;
  logic                   rej;

  modport master (
    output en, op, dir, in, load_data,
    input  out, depth, full, empty, ovf, rej
  );

  modport slave (
    input  en, op, dir, in, load_data,
    output out, depth, full, empty, ovf, rej
  );
endinterface

// File: rtl/digit_entry_reg.sv
// Multi-mode digit register for the calculator operand path: directional
// shift-in, backspace, rotate, parallel load and clear, with entry tracking.
module digit_entry_reg #(
  parameter int COUNT     = 4,
  parameter int WIDTH     = 4,
  parameter int DIGIT_MAX = 9,
  parameter bit SATURATE  = 1'b1
) (
  input logic             trig,
  input logic             reset,
  digit_entry_reg_if.slave bus
);
  localparam int N  = COUNT * WIDTH;
  localparam int DW = $clog2(COUNT + 1);

  localparam logic [WIDTH-1:0] DMAX     = WIDTH'(DIGIT_MAX);
  localparam logic [DW-1:0]    CNT_FULL = DW'(COUNT);

  localparam logic [2:0] OP_SHIFT  = 3'b001;
  localparam logic [2:0] OP_DELETE = 3'b010;
  localparam logic [2:0] OP_ROTATE = 3'b011;
  localparam logic [2:0] OP_LOAD   = 3'b100;
  localparam logic [2:0] OP_CLEAR  = 3'b101;

  logic [N-1:0]  data;
  logic [DW-1:0] cnt;
  logic          ovf_q;
  logic          rej_q;

  logic [N-1:0] shifted;
  logic [N-1:0] deleted;
  logic [N-1:0] rotated;
  logic         digit_ok;
  logic         is_full;
  logic         is_empty;

  // dir=0 enters at the LSB slot; dir=1 enters at the MSB slot.
  always_comb begin
    shifted = data;
    deleted = data;
    rotated = data;
    if (!bus.dir) begin
      shifted = {data[N-WIDTH-1:0], bus.in};
      deleted = {{WIDTH{1'b0}}, data[N-1:WIDTH]};
      rotated = {data[N-WIDTH-1:0], data[N-1:N-WIDTH]};
    end else begin
      shifted = {bus.in, data[N-1:WIDTH]};
      deleted = {data[N-WIDTH-1:0], {WIDTH{1'b0}}};
      rotated = {data[WIDTH-1:0], data[N-1:WIDTH]};
    end
  end

  assign digit_ok = (bus.in <= DMAX);
  assign is_full  = (cnt == CNT_FULL);
  assign is_empty = (cnt == '0);

  always_ff @(posedge trig or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      rej_q <= 1'b0;
      if (bus.en) begin
        case (bus.op)
          OP_SHIFT: begin
            if (!digit_ok) begin
              rej_q <= 1'b1;
            end else if (!is_full) begin
              data <= shifted;
              cnt  <= cnt + 1'b1;
            end else if (SATURATE) begin
              rej_q <= 1'b1;
            end else begin
              // Wrap mode: the far-end digit falls off and depth stays at COUNT.
              data  <= shifted;
              ovf_q <= 1'b1;
            end
          end
          OP_DELETE: begin
            if (is_empty) begin
              rej_q <= 1'b1;
            end else begin
              data <= deleted;
              cnt  <= cnt - 1'b1;
            end
          end
          OP_ROTATE: data <= rotated;
          OP_LOAD: begin
            data <= bus.load_data;
            cnt  <= CNT_FULL;
          end
          OP_CLEAR: begin
            data <= '0;
            cnt  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.out   = data;
  assign bus.depth = cnt;
  assign bus.full  = is_full;
  assign bus.empty = is_empty;
  assign bus.ovf   = ovf_q;
  assign bus.rej   = rej_q;
endmodule

// File: tb/tb_digit_entry_reg.sv
// Bench for digit_entry_reg: a saturating and a wrapping instance share stimulus
// and are checked against an arithmetic model of the operand value.
module tb_digit_entry_reg;
  localparam int COUNT = 4;
  localparam int WIDTH = 4;
  localparam int DMAX  = 9;
  localparam int BASE  = 1 << WIDTH;
  localparam int MOD   = 1 << (COUNT * WIDTH);
  localparam int TOP   = MOD / BASE;

  logic trig;
  logic reset;

  digit_entry_reg_if #(.COUNT(COUNT), .WIDTH(WIDTH)) bus0 ();
  digit_entry_reg_if #(.COUNT(COUNT), .WIDTH(WIDTH)) bus1 ();

  digit_entry_reg #(.COUNT(COUNT), .WIDTH(WIDTH), .DIGIT_MAX(DMAX), .SATURATE(1'b1))
    dut_sat (.trig(trig), .reset(reset), .bus(bus0));
  digit_entry_reg #(.COUNT(COUNT), .WIDTH(WIDTH), .DIGIT_MAX(DMAX), .SATURATE(1'b0))
    dut_wrap (.trig(trig), .reset(reset), .bus(bus1));

  initial trig = 1'b0;
  always #5 trig = ~trig;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: index 0 = saturating instance, 1 = wrapping instance.
  int m_val[2];
  int m_depth[2];
  bit m_ovf[2];
  bit m_rej[2];

  logic              s_en;
  logic [2:0]        s_op;
  logic              s_dir;
  logic [WIDTH-1:0]  s_in;
  logic [COUNT*WIDTH-1:0] s_ld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_depth[k] = 0; m_ovf[k] = 0; m_rej[k] = 0;
    end
  endtask

  function automatic int shift_in(int v, bit d, int digit);
    if (!d) return (v * BASE) % MOD + digit;
    else    return v / BASE + digit * TOP;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 0;
      m_rej[k] = 0;
      if (s_en) begin
        case (int'(s_op))
          1: begin
            if (int'(s_in) > DMAX) m_rej[k] = 1;
            else if (m_depth[k] < COUNT) begin
              m_val[k] = shift_in(m_val[k], s_dir, int'(s_in));
              m_depth[k]++;
            end else if (k == 0) m_rej[k] = 1;
            else begin
              m_val[k] = shift_in(m_val[k], s_dir, int'(s_in));
              m_ovf[k] = 1;
            end
          end
          2: begin
            if (m_depth[k] == 0) m_rej[k] = 1;
            else begin
              m_val[k] = s_dir ? (m_val[k] * BASE) % MOD : m_val[k] / BASE;
              m_depth[k]--;
            end
          end
          3: m_val[k] = s_dir ? m_val[k] / BASE + (m_val[k] % BASE) * TOP
                              : (m_val[k] * BASE) % MOD + m_val[k] / TOP;
          4: begin m_val[k] = int'(s_ld); m_depth[k] = COUNT; end
          5: begin m_val[k] = 0; m_depth[k] = 0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " sat.out"},   32'(bus0.out),   32'(m_val[0]));
    check({tag, " sat.depth"}, 32'(bus0.depth), 32'(m_depth[0]));
    check({tag, " sat.full"},  32'(bus0.full),  32'(m_depth[0] == COUNT));
    check({tag, " sat.empty"}, 32'(bus0.empty), 32'(m_depth[0] == 0));
    check({tag, " sat.ovf"},   32'(bus0.ovf),   32'(m_ovf[0]));
    check({tag, " sat.rej"},   32'(bus0.rej),   32'(m_rej[0]));
    check({tag, " wrap.out"},   32'(bus1.out),   32'(m_val[1]));
    check({tag, " wrap.depth"}, 32'(bus1.depth), 32'(m_depth[1]));
    check({tag, " wrap.full"},  32'(bus1.full),  32'(m_depth[1] == COUNT));
    check({tag, " wrap.empty"}, 32'(bus1.empty), 32'(m_depth[1] == 0));
    check({tag, " wrap.ovf"},   32'(bus1.ovf),   32'(m_ovf[1]));
    check({tag, " wrap.rej"},   32'(bus1.rej),   32'(m_rej[1]));
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic dir,
                       input logic [WIDTH-1:0] din, input logic [COUNT*WIDTH-1:0] ld);
    s_en = en; s_op = op; s_dir = dir; s_in = din; s_ld = ld;
    bus0.en = en; bus0.op = op; bus0.dir = dir; bus0.in = din; bus0.load_data = ld;
    bus1.en = en; bus1.op = op; bus1.dir = dir; bus1.in = din; bus1.load_data = ld;
  endtask

  task automatic step(input string tag, input logic en, input logic [2:0] op, input logic dir,
                      input logic [WIDTH-1:0] din, input logic [COUNT*WIDTH-1:0] ld);
    drive(en, op, dir, din, ld);
    @(posedge trig);
    #1;
    model_step();
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge trig);
    @(negedge trig);
    reset = 1'b1;
    #1;
    check_all("reset_hold");

    step("sh1", 1, 3'b001, 0, 4'h1, '0);
    step("sh2", 1, 3'b001, 0, 4'h2, '0);
    step("sh3", 1, 3'b001, 0, 4'h3, '0);
    check("tp_0123", 32'(bus0.out), 32'h0123);
    step("sh4", 1, 3'b001, 0, 4'h4, '0);
    check("tp_1234", 32'(bus0.out), 32'h1234);
    step("sh5_full", 1, 3'b001, 0, 4'h5, '0);
    check("tp_sat_rej", 32'(bus0.rej), 32'h1);
    check("tp_wrap_2345", 32'(bus1.out), 32'h2345);
    check("tp_wrap_ovf", 32'(bus1.ovf), 32'h1);
    step("nop_after", 1, 3'b000, 0, 4'h0, '0);

    // Asynchronous reset between edges while the saturating copy holds 1234.
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_out", 32'(bus0.out), 32'h0);
    check_all("async_rst");
    @(negedge trig);
    reset = 1'b1;
    #1;
    check_all("rst_release");

    step("r_sh7", 1, 3'b001, 1, 4'h7, '0);
    step("r_sh8", 1, 3'b001, 1, 4'h8, '0);
    check("tp_8700", 32'(bus0.out), 32'h8700);
    step("r_del1", 1, 3'b010, 1, 4'h0, '0);
    check("tp_7000", 32'(bus0.out), 32'h7000);
    step("r_del2", 1, 3'b010, 1, 4'h0, '0);
    step("r_del_empty", 1, 3'b010, 1, 4'h0, '0);
    check("tp_del_rej", 32'(bus0.rej), 32'h1);

    step("bad_digit", 1, 3'b001, 0, 4'hA, '0);
    step("bad_digit_en0", 0, 3'b001, 0, 4'hA, '0);
    step("digit_max", 1, 3'b001, 0, 4'h9, '0);

    step("load", 1, 3'b100, 0, 4'h0, 16'hABCD);
    step("rot_l", 1, 3'b011, 0, 4'h0, '0);
    check("tp_bcda", 32'(bus0.out), 32'hBCDA);
    step("rot_r", 1, 3'b011, 1, 4'h0, '0);
    check("tp_abcd", 32'(bus0.out), 32'hABCD);
    step("op6_nop", 1, 3'b110, 0, 4'h1, '0);
    step("clear", 1, 3'b101, 0, 4'h0, '0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] rop;
      rop = ($urandom_range(0, 9) < 5) ? 3'b001 : 3'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 99) < 88), rop, 1'($urandom_range(0, 1)),
           WIDTH'($urandom_range(0, 11)), (COUNT*WIDTH)'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
